// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: turns scanner key events into BCD entries and function-key commands.
// Optional idle discard of a partial entry is compiled in with `define ENTRY_TIMEOUT_EN.
module keypad_entry_buffer #(
  parameter int NDIG        = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_code,
  input  logic              key_valid,
  output logic [4*NDIG-1:0] digits,
  output logic [3:0]        digit_count,
  output logic [4*NDIG-1:0] out_data,
  output logic [3:0]        out_cmd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              timeout,
  output logic [1:0]        state_dbg
);

  // Handshake: a result is transferred on the rising edge where out_valid & out_ready;
  // out_data/out_cmd are stable while out_valid is high and the producer never drops
  // out_valid before the transfer.

  localparam int         DW     = 4 * NDIG;
  localparam logic [3:0] NDIG_C = 4'(NDIG);

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, HOLD = 2'd2} state_t;

  state_t     state;
  logic       last_valid;
  logic [3:0] last_code;
  logic       evt;
  logic [3:0] evt_code;

  assign state_dbg = state;

  // A held key produces one event; a code change under a held level is a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_code  <= 4'h0;
      evt        <= 1'b0;
      evt_code   <= 4'h0;
    end else begin
      evt        <= key_valid & (~last_valid | (key_code != last_code));
      evt_code   <= key_code;
      last_valid <= key_valid;
      last_code  <= key_code;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int             TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tmr;
  logic          to_fire;

  assign to_fire = (state == ENTRY) && !evt && (tmr == TMAX);
`else
  logic to_fire;

  assign to_fire = 1'b0;
  // Always 0; the comparison only keeps TIMEOUT_CYC referenced in this build.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      digits      <= '0;
      digit_count <= 4'd0;
      out_data    <= '0;
      out_cmd     <= 4'h0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      timeout     <= 1'b0;
      tmr         <= '0;
`endif
    end else begin
      overflow <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      timeout  <= 1'b0;
      if (state != HOLD) begin
        if (evt || to_fire || state == IDLE) tmr <= '0;
        else                                 tmr <= tmr + 1'b1;
      end
`endif
      case (state)
        HOLD: begin
          // Events during HOLD are dropped; nothing is queued behind the pending result.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= (digit_count != 4'd0) ? ENTRY : IDLE;
          end
        end
        default: begin
          if (to_fire) begin
            digits      <= '0;
            digit_count <= 4'd0;
            state       <= IDLE;
`ifdef ENTRY_TIMEOUT_EN
            timeout     <= 1'b1;
`endif
          end else if (evt) begin
            case (evt_code)
              4'hE: begin
                if (digit_count != 4'd0) begin
                  digits      <= digits >> 4;
                  digit_count <= digit_count - 4'd1;
                  state       <= (digit_count == 4'd1) ? IDLE : ENTRY;
                end
              end
              4'hF: begin
                if (digit_count != 4'd0) begin
                  out_data    <= digits;
                  out_cmd     <= 4'h0;
                  out_valid   <= 1'b1;
                  digits      <= '0;
                  digit_count <= 4'd0;
                  state       <= HOLD;
                end
              end
              4'hA, 4'hB, 4'hC, 4'hD: begin
                // Function keys leave the partial entry intact for when HOLD ends.
                out_data  <= '0;
                out_cmd   <= evt_code;
                out_valid <= 1'b1;
                state     <= HOLD;
              end
              default: begin
                if (digit_count < NDIG_C) begin
                  digits      <= (digits << 4) | DW'(evt_code);
                  digit_count <= digit_count + 4'd1;
                  state       <= ENTRY;
                end else begin
                  overflow <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed key sequences, handshake results checked
// against an expected queue by an independent output monitor.
module tb_keypad_entry_buffer;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
`ifdef ENTRY_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 50_000_000;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     key_code = 4'h0;
  logic           key_valid = 1'b0;
  logic [W-1:0]   digits;
  logic [3:0]     digit_count;
  logic [W-1:0]   out_data;
  logic [3:0]     out_cmd;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           overflow;
  logic           timeout;
  logic [1:0]     state_dbg;

  int checks = 0;
  int failures = 0;
  int accepts = 0;
  int ov_cnt = 0;
  int to_cnt = 0;
  logic prev_ov = 1'b0;
  logic prev_to = 1'b0;
  logic [W+3:0] exp_q[$];

  keypad_entry_buffer #(.NDIG(NDIG), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .digits(digits), .digit_count(digit_count), .out_data(out_data),
    .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .timeout(timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one clean press, released long enough for the next identical key to register
  task automatic press(input logic [3:0] c);
    @(posedge clk); #1;
    key_code  = c;
    key_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got cmd=%h data=%h, expected none", out_cmd, out_data);
        end else begin
          logic [W+3:0] e;
          e = exp_q.pop_front();
          accepts++;
          if ({out_cmd, out_data} !== e) begin
            failures++;
            $display("FAIL output: got cmd=%h data=%h expected cmd=%h data=%h",
                     out_cmd, out_data, e[W+3:W], e[W-1:0]);
          end
        end
      end
      if (overflow) ov_cnt++;
      if (timeout) to_cnt++;
      if ((overflow && timeout) || (overflow && prev_ov) || (timeout && prev_to)) begin
        checks++;
        failures++;
        $display("FAIL pulse_rules: overflow=%b timeout=%b prev_ov=%b prev_to=%b, expected single-cycle exclusive pulses",
                 overflow, timeout, prev_ov, prev_to);
      end
    end
    prev_ov = overflow;
    prev_to = timeout;
  end

  initial begin : stim
    int held;
    int ov0;
    bit seen;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    // 1,2,3,# -> entry 0123
    press(4'h1); press(4'h2); press(4'h3);
    @(negedge clk);
    check("entry_digits", 32'(digits), 32'h0123);
    check("entry_count", 32'(digit_count), 32'd3);
    exp_q.push_back({4'h0, 16'h0123});
    press(4'hF);
    @(negedge clk);
    check("enter_cleared", 32'(digits), 32'h0);
    check("enter_count", 32'(digit_count), 32'd0);
    check("enter_valid_low", 32'(out_valid), 32'h0);
    check("enter_state", 32'(state_dbg), 32'd0);

    // overflow on the fifth digit
    ov0 = ov_cnt;
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    @(negedge clk);
    check("full_digits", 32'(digits), 32'h9876);
    check("full_no_ovf", 32'(ov_cnt - ov0), 32'd0);
    press(4'h5);
    @(negedge clk);
    check("ovf_digits", 32'(digits), 32'h9876);
    check("ovf_count", 32'(digit_count), 32'd4);
    check("ovf_pulses", 32'(ov_cnt - ov0), 32'd1);
    exp_q.push_back({4'h0, 16'h9876});
    press(4'hF);

    // backspace down to empty and one more in IDLE
    press(4'h4); press(4'h5);
    @(negedge clk);
    check("bs_start", 32'(digits), 32'h0045);
    press(4'hE);
    @(negedge clk);
    check("bs_1", 32'(digits), 32'h0004);
    press(4'hE);
    @(negedge clk);
    check("bs_2", 32'(digits), 32'h0000);
    check("bs_2_state", 32'(state_dbg), 32'd0);
    press(4'hE);
    @(negedge clk);
    check("bs_3_count", 32'(digit_count), 32'd0);
    check("bs_3_state", 32'(state_dbg), 32'd0);

    // function key held by back-pressure, with a discarded key during HOLD
    press(4'h7);
    out_ready = 1'b0;
    exp_q.push_back({4'hB, 16'h0000});
    @(negedge clk);
    key_code = 4'hB;
    key_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("cmd_seen", 32'(seen), 32'd1);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid && out_cmd == 4'hB && out_data == '0) held++;
      if (i == 3) key_valid = 1'b0;
      if (i == 5) begin key_code = 4'h2; key_valid = 1'b1; end
      if (i == 7) key_valid = 1'b0;
    end
    check("cmd_held_cycles", 32'(held), 32'd10);
    check("cmd_hold_digits", 32'(digits), 32'h0007);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("cmd_after_valid", 32'(out_valid), 32'h0);
    check("cmd_after_digits", 32'(digits), 32'h0007);
    check("cmd_after_state", 32'(state_dbg), 32'd1);
    press(4'hE);

    // held key level: 3, 3 (no event), 5
    @(posedge clk); #1;
    key_code = 4'h3; key_valid = 1'b1;
    repeat (3) @(posedge clk); #1 key_code = 4'h3;
    repeat (3) @(posedge clk); #1 key_code = 4'h5;
    repeat (3) @(posedge clk); #1 key_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_key_digits", 32'(digits), 32'h0035);
    check("hold_key_count", 32'(digit_count), 32'd2);
    exp_q.push_back({4'h0, 16'h0035});
    press(4'hF);

    // '#' in IDLE emits nothing; function key from IDLE
    press(4'hF);
    exp_q.push_back({4'hA, 16'h0000});
    press(4'hA);
    @(negedge clk);
    check("fkey_idle_state", 32'(state_dbg), 32'd0);

`ifdef ENTRY_TIMEOUT_EN
    begin
      int to0;
      to0 = to_cnt;
      press(4'h6);
      repeat (110) @(negedge clk);
      check("timeout_pulses", 32'(to_cnt - to0), 32'd1);
      check("timeout_digits", 32'(digits), 32'h0);
      check("timeout_state", 32'(state_dbg), 32'd0);
    end
`else
    check("timeout_never", 32'(to_cnt), 32'd0);
`endif

    // asynchronous reset in the middle of HOLD with a partial entry
    press(4'h1);
    out_ready = 1'b0;
    press(4'hC);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_digits", 32'(digits), 32'h0);
    check("async_rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("accept_total", 32'(accepts), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
